pc_target_table: RTL and testbench

PC_TARGET_TABLE -- requirements
Module: pc_target_table

---
 rtl/pc_target_table.sv | 67 ++++++
 tb/tb_pc_target_table.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pc_target_table.sv
// pc_target_table: indexed branch-target table with absolute/relative entries,
// one-cycle registered lookup, write-first bypass and a saturating miss counter.
module pc_target_table #(
    parameter int D = 10,
    parameter int N = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_rel,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    input  logic [D-1:0]  pc_in,
    output logic          rd_valid,
    output logic [D-1:0]  target,
    output logic          hit,
    output logic [7:0]    miss_cnt
);
    logic [N-1:0] valid;
    logic [N-1:0] rel;
    logic [D-1:0] value [N];
    logic         bypass;
    logic         e_valid;
    logic         e_rel;
    logic [D-1:0] e_val;
    logic [D-1:0] next_target;

    // A same-index write lands in the lookup result at the same edge
    always_comb begin
        bypass      = wr_en && (wr_addr == rd_addr);
        e_valid     = bypass || valid[rd_addr];
        e_rel       = bypass ? wr_rel : rel[rd_addr];
        e_val       = bypass ? wr_data : value[rd_addr];
        next_target = !e_valid ? pc_in + D'(1) : e_rel ? pc_in + e_val : e_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            rel   <= '0;
            for (int i = 0; i < N; i++) value[i] <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= 1'b1;
            rel[wr_addr]   <= wr_rel;
            value[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            target   <= '0;
            hit      <= 1'b0;
            miss_cnt <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                target <= next_target;
                hit    <= e_valid;
                if (!e_valid && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_pc_target_table.sv
// tb_pc_target_table: directed checks of pc_target_table at default size and at N=64, D=16.
module tb_pc_target_table;
    logic       clk = 0;
    logic       reset_n = 0;
    logic       wr_en = 0, wr_rel = 0, rd_req = 0;
    logic [3:0] wr_addr = 0, rd_addr = 0;
    logic [9:0] wr_data = 0, pc_in = 0;
    logic       rd_valid, hit;
    logic [9:0] target;
    logic [7:0] miss_cnt;

    logic        b_wr_en = 0, b_wr_rel = 0, b_rd_req = 0;
    logic [5:0]  b_wr_addr = 0, b_rd_addr = 0;
    logic [15:0] b_wr_data = 0, b_pc_in = 0;
    logic        b_rd_valid, b_hit;
    logic [15:0] b_target;
    logic [7:0]  b_miss_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_target_table dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_rel(wr_rel), .rd_req(rd_req), .rd_addr(rd_addr), .pc_in(pc_in),
        .rd_valid(rd_valid), .target(target), .hit(hit), .miss_cnt(miss_cnt)
    );

    pc_target_table #(.D(16), .N(64)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_rel(b_wr_rel), .rd_req(b_rd_req), .rd_addr(b_rd_addr), .pc_in(b_pc_in),
        .rd_valid(b_rd_valid), .target(b_target), .hit(b_hit), .miss_cnt(b_miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write(input logic [3:0] a, input logic [9:0] d, input logic r);
        @(negedge clk);
        wr_en = 1; wr_addr = a; wr_data = d; wr_rel = r;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic lookup(input logic [3:0] a, input logic [9:0] pc);
        @(negedge clk);
        rd_req = 1; rd_addr = a; pc_in = pc;
        @(negedge clk);
        rd_req = 0;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] t, input logic h, input logic [7:0] m);
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_target"}, target, t);
        check({tag, "_hit"}, hit, h);
        check({tag, "_miss"}, miss_cnt, m);
    endtask

    initial begin
        #1;
        check("rst_valid", rd_valid, 0);
        check("rst_target", target, 0);
        check("rst_hit", hit, 0);
        check("rst_miss", miss_cnt, 0);
        @(negedge clk);
        reset_n = 1;

        lookup(3, 40);
        expect_out("miss_first", 41, 0, 1);
        @(negedge clk);
        check("idle_valid", rd_valid, 0);
        check("hold_target", target, 41);

        write(1, 105, 0);
        lookup(1, 7);
        expect_out("abs", 105, 1, 1);

        write(2, 10'h3FB, 1);
        lookup(2, 4);
        expect_out("rel_neg", 10'h3FF, 1, 1);
        write(2, 20, 1);
        lookup(2, 1020);
        expect_out("rel_wrap", 16, 1, 1);

        @(negedge clk);
        wr_en = 1; wr_addr = 5; wr_data = 93; wr_rel = 0;
        rd_req = 1; rd_addr = 5; pc_in = 0;
        @(negedge clk);
        wr_en = 0; rd_req = 0;
        expect_out("bypass", 93, 1, 1);

        @(negedge clk);
        wr_en = 1; wr_addr = 6; wr_data = 200; wr_rel = 0;
        rd_req = 1; rd_addr = 1; pc_in = 0;
        @(negedge clk);
        wr_en = 0; rd_req = 0;
        expect_out("indep", 105, 1, 1);
        lookup(6, 0);
        expect_out("indep_wr", 200, 1, 1);

        @(negedge clk);
        rd_req = 1; rd_addr = 1; pc_in = 50;
        @(negedge clk);
        expect_out("b2b0", 105, 1, 1);
        rd_addr = 5;
        @(negedge clk);
        expect_out("b2b1", 93, 1, 1);
        rd_addr = 3;
        @(negedge clk);
        expect_out("b2b2", 51, 0, 2);
        rd_req = 0;
        @(negedge clk);
        check("b2b_end_valid", rd_valid, 0);

        rd_req = 1; rd_addr = 3; pc_in = 0;
        repeat (300) @(negedge clk);
        rd_req = 0;
        @(negedge clk);
        check("sat_miss", miss_cnt, 255);

        lookup(3, 9);
        check("sat_hold", miss_cnt, 255);

        @(negedge clk);
        rd_req = 1; rd_addr = 1; pc_in = 7;
        @(posedge clk);
        #2;
        check("pre_rst_valid", rd_valid, 1);
        reset_n = 0;
        #1;
        check("async_valid", rd_valid, 0);
        check("async_target", target, 0);
        check("async_hit", hit, 0);
        check("async_miss", miss_cnt, 0);
        @(negedge clk);
        rd_req = 0;
        reset_n = 1;
        @(negedge clk);
        check("no_stray_valid", rd_valid, 0);
        lookup(1, 7);
        expect_out("cleared", 8, 0, 1);

        @(negedge clk);
        b_wr_en = 1; b_wr_addr = 63; b_wr_data = 16'hFFFF; b_wr_rel = 0;
        @(negedge clk);
        b_wr_en = 0;
        b_rd_req = 1; b_rd_addr = 63; b_pc_in = 16'h1234;
        @(negedge clk);
        b_rd_req = 0;
        check("wide_valid", b_rd_valid, 1);
        check("wide_target", b_target, 16'hFFFF);
        check("wide_hit", b_hit, 1);
        check("wide_miss", b_miss_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
